bist_response_checker: RTL and testbench

Synthesizable self-test controller for a 3-input, 1-output combinational block such as the gate-level `simple_circuit`. It is the hardware counterpart of a stimulus-only bench: it drives all eight input patterns onto `pat`, samples the block's `resp` after a programmable settle time, and compares each sample against a parameterised truth table. It reports pass/fail, mismatch count and the first failing pattern. It sits beside the block under test, with `pat` wired to the block's inputs and the block's output wired to `resp`.

---
 rtl/bist_response_checker.sv | 117 +++++++++++
 tb/tb_bist_response_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bist_response_checker.sv
// Self-test controller for a 3-input, 1-output combinational block: walks all eight
// input patterns, samples the response after SETTLE idle cycles and scores it against EXPECTED.
module bist_response_checker #(
    parameter logic [7:0] EXPECTED = 8'h10,
    parameter int         SETTLE   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       resp,
    output logic [2:0] pat,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] first_fail,
    output logic       fail_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam bit         HAS_SETTLE  = (SETTLE > 0);
    localparam logic [3:0] SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [2:0] pat_n, first_fail_n;
    logic [3:0] err_cnt_n;
    logic       busy_n, done_n, pass_n, fail_valid_n;
    logic       mismatch;

    assign mismatch = (resp != EXPECTED[pat]);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        pat_n        = pat;
        busy_n       = busy;
        done_n       = 1'b0;
        pass_n       = pass;
        err_cnt_n    = err_cnt;
        first_fail_n = first_fail;
        fail_valid_n = fail_valid;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    pat_n        = 3'd0;
                    cnt_n        = 4'd0;
                    busy_n       = 1'b1;
                    pass_n       = 1'b0;
                    err_cnt_n    = 4'd0;
                    first_fail_n = 3'd0;
                    fail_valid_n = 1'b0;
                    state_n      = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
                end
            end
            ST_SETTLE: begin
                cnt_n = cnt + 4'd1;
                if (cnt == SETTLE_LAST) state_n = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_cnt_n = err_cnt + 4'd1;
                    if (!fail_valid) begin
                        first_fail_n = pat;
                        fail_valid_n = 1'b1;
                    end
                end
                if (pat != 3'd7) begin
                    pat_n   = pat + 3'd1;
                    cnt_n   = 4'd0;
                    state_n = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
                end else begin
                    // pass must see the count including the pattern-7 result
                    pat_n   = 3'd0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_cnt_n == 4'd0);
                    state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            pat        <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= 4'd0;
            first_fail <= 3'd0;
            fail_valid <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pat        <= pat_n;
            busy       <= busy_n;
            done       <= done_n;
            pass       <= pass_n;
            err_cnt    <= err_cnt_n;
            first_fail <= first_fail_n;
            fail_valid <= fail_valid_n;
        end
    end

endmodule

// File: tb/tb_bist_response_checker.sv
// Bench for bist_response_checker: one instance with SETTLE=0 and one with SETTLE=3,
// each scored at its done pulse against expectations queued when the run is launched.
module tb_bist_response_checker;

    localparam int GOOD = 0, STUCK0 = 1, STUCK1 = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start3;
    logic       resp0, resp3;
    logic [2:0] pat0, pat3, ff0, ff3;
    logic       busy0, busy3, done0, done3, pass0, pass3, fv0, fv3;
    logic [3:0] ec0, ec3;
    int         mode0, mode3;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int err;
        int ff;
        int fv;
        int ps;
        int lat;
        int t0;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    exp_t m0, m3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic model(input logic [2:0] p, input int m);
        if (m == STUCK0) return 1'b0;
        if (m == STUCK1) return 1'b1;
        return ~(p[0] | p[1]) & p[2];
    endfunction

    assign resp0 = model(pat0, mode0);
    assign resp3 = model(pat3, mode3);

    bist_response_checker #(.EXPECTED(8'h10), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .resp(resp0), .pat(pat0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(ec0),
        .first_fail(ff0), .fail_valid(fv0)
    );

    bist_response_checker #(.EXPECTED(8'h10), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .resp(resp3), .pat(pat3),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(ec3),
        .first_fail(ff3), .fail_valid(fv3)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string n, input logic [2:0] p, input logic b, input logic d,
                             input logic ps, input logic [3:0] ec, input logic [2:0] ff,
                             input logic fv);
        chk({n, " pat"}, int'(p), 0);
        chk({n, " busy"}, int'(b), 0);
        chk({n, " done"}, int'(d), 0);
        chk({n, " pass"}, int'(ps), 0);
        chk({n, " err_cnt"}, int'(ec), 0);
        chk({n, " first_fail"}, int'(ff), 0);
        chk({n, " fail_valid"}, int'(fv), 0);
    endtask

    // Scoreboard monitors: pop one expectation per done pulse
    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0 unexpected done at cycle %0d", cyc);
            end else begin
                m0 = q0.pop_front();
                chk("dut0 done latency", cyc - m0.t0, m0.lat);
                chk("dut0 err_cnt", int'(ec0), m0.err);
                chk("dut0 first_fail", int'(ff0), m0.ff);
                chk("dut0 fail_valid", int'(fv0), m0.fv);
                chk("dut0 pass", int'(pass0), m0.ps);
            end
        end
        if (done3) begin
            if (q3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut3 unexpected done at cycle %0d", cyc);
            end else begin
                m3 = q3.pop_front();
                chk("dut3 done latency", cyc - m3.t0, m3.lat);
                chk("dut3 err_cnt", int'(ec3), m3.err);
                chk("dut3 first_fail", int'(ff3), m3.ff);
                chk("dut3 fail_valid", int'(fv3), m3.fv);
                chk("dut3 pass", int'(pass3), m3.ps);
            end
        end
    end

    // Returns at the negedge following the accepting edge (edge 0)
    task automatic launch(input int which);
        @(negedge clk);
        if (which == 0) start0 = 1'b1;
        else start3 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic run0(input string n, input int m, input int err, input int ff, input int fv,
                        input int ps, input bit mid_start);
        exp_t e;
        mode0 = m;
        launch(0);
        e = '{err: err, ff: ff, fv: fv, ps: ps, lat: 8, t0: cyc};
        q0.push_back(e);
        for (int i = 0; i < 8; i++) begin
            chk({n, " pat step"}, int'(pat0), i);
            chk({n, " busy in run"}, int'(busy0), 1);
            start0 = (mid_start && i == 2);
            @(negedge clk);
        end
        start0 = 1'b0;
        chk({n, " busy after run"}, int'(busy0), 0);
        chk({n, " pat after run"}, int'(pat0), 0);
        @(negedge clk);
        chk({n, " done one cycle"}, int'(done0), 0);
        repeat (3) @(negedge clk);
        chk({n, " idle busy"}, int'(busy0), 0);
        chk({n, " held err_cnt"}, int'(ec0), err);
        chk({n, " held first_fail"}, int'(ff0), ff);
        chk({n, " held pass"}, int'(pass0), ps);
    endtask

    initial begin
        exp_t e;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start3 = 1'b0;
        mode0  = GOOD;
        mode3  = GOOD;
        repeat (3) @(negedge clk);
        chk_reset("reset dut0", pat0, busy0, done0, pass0, ec0, ff0, fv0);
        chk_reset("reset dut3", pat3, busy3, done3, pass3, ec3, ff3, fv3);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run0("good", GOOD, 0, 0, 0, 1, 1'b0);
        run0("stuck0", STUCK0, 1, 4, 1, 0, 1'b0);
        run0("stuck1 mid start", STUCK1, 7, 0, 1, 0, 1'b1);
        run0("good after fail", GOOD, 0, 0, 0, 1, 1'b0);

        // SETTLE=3: each pattern held four cycles, done on edge 32
        mode3 = GOOD;
        launch(1);
        e = '{err: 0, ff: 0, fv: 0, ps: 1, lat: 32, t0: cyc};
        q3.push_back(e);
        for (int k = 0; k < 32; k++) begin
            chk("settle3 pat hold", int'(pat3), k / 4);
            chk("settle3 busy", int'(busy3), 1);
            chk("settle3 no early done", int'(done3), 0);
            @(negedge clk);
        end
        chk("settle3 busy after run", int'(busy3), 0);
        repeat (3) @(negedge clk);

        // Asynchronous reset in cycle 10 of a failing run
        mode3 = STUCK1;
        launch(1);
        repeat (9) @(negedge clk);
        chk("pre-reset err_cnt", int'(ec3), 2);
        chk("pre-reset fail_valid", int'(fv3), 1);
        chk("pre-reset pat", int'(pat3), 2);
        #1 rst_n = 1'b0;
        #1 chk_reset("async reset dut3", pat3, busy3, done3, pass3, ec3, ff3, fv3);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post-reset idle busy", int'(busy3), 0);

        mode3 = GOOD;
        launch(1);
        e = '{err: 0, ff: 0, fv: 0, ps: 1, lat: 32, t0: cyc};
        q3.push_back(e);
        repeat (36) @(negedge clk);

        chk("dut0 all runs completed", q0.size(), 0);
        chk("dut3 all runs completed", q3.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
